// File: rtl/mtf_encoder.sv
// mtf_encoder: move-to-front encoder for the BWT output stream.
// Each accepted byte is replaced by its rank in a 256-entry recency list,
// and then moved to the front. The search and the shift are done in one pass,
// at one list entry per cycle. A block of `length` symbols is programmed by
// `start`. Completion raises `done_flag`.
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start, i_length    block start pulse and symbol count (sampled on start)
//   i_in_char/i_in_valid input symbol stream; o_in_ready accepts a symbol
//   o_out_rank/valid     registered rank output; i_out_ready consumes it
//   o_done_flag          all symbols of the block emitted
module mtf_encoder (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic [9:0] i_length,
    input  logic [7:0] i_in_char,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [7:0] o_out_rank,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_done_flag
);

    typedef enum logic [2:0] {StWait, StInit, StIdle, StScan, StOut, StDone} state_t;

    state_t     r_state;
    logic [9:0] r_len;
    logic [9:0] r_emit_cnt;
    logic [7:0] r_init_cnt;
    logic       r_init_last;  // all 256 entries written, leave INIT next edge
    logic [7:0] r_sym;
    logic [7:0] r_idx;
    logic [7:0] r_carry;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [7:0] r_out_rank;
    logic       r_done_flag;

    logic [7:0] r_table [256];

    logic       w_wr_en;
    logic [7:0] w_wr_addr;
    logic [7:0] w_wr_data;
    logic [7:0] w_rd_data;
    logic       w_match;
    logic [9:0] w_emit_next;

    assign w_rd_data   = r_table[r_idx];
    assign w_match     = (w_rd_data == r_sym);
    assign w_emit_next = r_emit_cnt + 10'd1;

    // List write port. A pending start suppresses writes, because INIT rebuilds the list anyway.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_idx;
        w_wr_data = r_carry;
        if (!i_start) begin
            case (r_state)
                StInit: begin
                    if (!r_init_last) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_init_cnt;
                        w_wr_data = r_init_cnt;
                    end
                end
                StScan: begin
                    // Entry 0 takes the new symbol. Later entries take the carried-down entry.
                    // A hit at entry 0 leaves the list unchanged.
                    w_wr_en   = !((r_idx == 8'd0) && w_match);
                    w_wr_data = (r_idx == 8'd0) ? r_sym : r_carry;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_table[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StWait;
            r_len       <= 10'd0;
            r_emit_cnt  <= 10'd0;
            r_init_cnt  <= 8'd0;
            r_init_last <= 1'b0;
            r_sym       <= 8'd0;
            r_idx       <= 8'd0;
            r_carry     <= 8'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_rank  <= 8'd0;
            r_done_flag <= 1'b0;
        end else if (i_start) begin
            r_state     <= StInit;
            r_len       <= i_length;
            r_emit_cnt  <= 10'd0;
            r_init_cnt  <= 8'd0;
            r_init_last <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_done_flag <= 1'b0;
        end else begin
            case (r_state)
                StInit: begin
                    if (!r_init_last) begin
                        r_init_cnt <= r_init_cnt + 8'd1;
                        if (r_init_cnt == 8'hFF) begin
                            r_init_last <= 1'b1;
                        end
                    end else if (r_len == 10'd0) begin
                        r_state     <= StDone;
                        r_done_flag <= 1'b1;
                    end else begin
                        r_state    <= StIdle;
                        r_in_ready <= 1'b1;
                    end
                end
                StIdle: begin
                    if (i_in_valid && r_in_ready) begin
                        r_sym      <= i_in_char;
                        r_idx      <= 8'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= StScan;
                    end
                end
                StScan: begin
                    if (w_match) begin
                        r_out_rank  <= r_idx;
                        r_out_valid <= 1'b1;
                        r_state     <= StOut;
                    end else begin
                        r_carry <= w_rd_data;
                        r_idx   <= r_idx + 8'd1;
                    end
                end
                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_emit_cnt  <= w_emit_next;
                        if (w_emit_next == r_len) begin
                            r_state     <= StDone;
                            r_done_flag <= 1'b1;
                        end else begin
                            r_state    <= StIdle;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                default: ;  // WAIT and DONE leave only on start
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_rank  = r_out_rank;
    assign o_out_valid = r_out_valid;
    assign o_done_flag = r_done_flag;

endmodule

// File: tb/tb_mtf_encoder.sv
// Directed bench for mtf_encoder: vector tables for the main streams and
// hand-written sequences for backpressure, restart, zero length and reset.
module tb_mtf_encoder;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready, out_valid, out_ready, done_flag;
    logic [9:0] length;
    logic [7:0] in_char, out_rank;

    int n_cmp = 0;
    int n_err = 0;
    bit seen_ov;

    always #5 clk = ~clk;

    mtf_encoder dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_length    (length),
        .i_in_char   (in_char),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_out_rank  (out_rank),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_done_flag (done_flag)
    );

    typedef struct {
        logic [7:0] sym;
        logic [7:0] rank;
        bit         last;
    } vec_t;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [9:0] len);
        start  = 1'b1;
        length = len;
        tick();
        start  = 1'b0;
    endtask

    // Count edges from start until IDLE or DONE is reached.
    task automatic wait_init(input string name);
        int n = 0;
        seen_ov = 1'b0;
        while (!(in_ready || done_flag) && n < 400) begin
            tick();
            n++;
            if (out_valid) seen_ov = 1'b1;
        end
        chk({name, " init cycles"}, n, 257);
    endtask

    task automatic feed(input logic [7:0] sym, input logic [7:0] rank, input bit last,
                        input string name);
        int n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk({name, " in_ready"}, 0, 1);
            return;
        end
        in_char  = sym;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        chk({name, " latency"}, n, rank + 1);
        chk({name, " rank"}, out_rank, rank);
        tick();
        chk({name, " out_valid after"}, out_valid, 0);
        chk({name, " done"}, done_flag, last);
        chk({name, " in_ready after"}, in_ready, !last);
    endtask

    initial begin
        vec_t v1[4];
        vec_t v2[6];
        bit   bad_rank, bad_valid, bad_ready;
        logic [7:0] held;

        v1[0] = '{8'h62, 8'h62, 1'b0};
        v1[1] = '{8'h62, 8'h00, 1'b0};
        v1[2] = '{8'h61, 8'h62, 1'b0};
        v1[3] = '{8'h62, 8'h01, 1'b1};

        v2[0] = '{8'h00, 8'h00, 1'b0};
        v2[1] = '{8'hFF, 8'hFF, 1'b0};
        v2[2] = '{8'hFF, 8'h00, 1'b0};
        v2[3] = '{8'h00, 8'h01, 1'b0};
        v2[4] = '{8'h05, 8'h06, 1'b0};
        v2[5] = '{8'h03, 8'h05, 1'b1};

        rst_n = 1'b1; start = 1'b0; length = '0; in_char = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_rank", out_rank, 0);
        chk("reset done", done_flag, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("wait in_ready", in_ready, 0);

        // Basic stream, length 4.
        do_start(10'd4);
        wait_init("t1");
        for (int i = 0; i < 4; i++) feed(v1[i].sym, v1[i].rank, v1[i].last, $sformatf("t1[%0d]", i));
        repeat (3) tick();
        chk("t1 done held", done_flag, 1);

        // Latency extremes on a fresh list.
        do_start(10'd6);
        wait_init("t2");
        chk("t2 done cleared", done_flag, 0);
        for (int i = 0; i < 6; i++) feed(v2[i].sym, v2[i].rank, v2[i].last, $sformatf("t2[%0d]", i));

        // Backpressure: hold for 10 cycles, then exactly one consume.
        do_start(10'd2);
        wait_init("bp");
        out_ready = 1'b0;
        in_char   = 8'h10;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int n = 0; n < 300 && !out_valid; n++) tick();
        chk("bp out_valid", out_valid, 1);
        held = out_rank;
        chk("bp rank", held, 8'h10);
        bad_rank = 0; bad_valid = 0; bad_ready = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (out_rank !== held) bad_rank = 1;
            if (out_valid !== 1'b1) bad_valid = 1;
            if (in_ready !== 1'b0) bad_ready = 1;
        end
        chk("bp rank stable", bad_rank, 0);
        chk("bp valid held", bad_valid, 0);
        chk("bp in_ready low", bad_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp one consume valid", out_valid, 0);
        chk("bp one consume done", done_flag, 0);
        chk("bp one consume ready", in_ready, 1);
        out_ready = 1'b1;
        feed(8'h10, 8'h00, 1'b1, "bp second");

        // Start mid-scan drops the symbol and rebuilds the list.
        do_start(10'd1);
        wait_init("ms");
        in_char  = 8'h80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        chk("ms mid scan valid", out_valid, 0);
        do_start(10'd1);
        wait_init("ms restart");
        chk("ms no out_valid", seen_ov, 0);
        feed(8'h80, 8'h80, 1'b1, "ms after");

        // Zero length: straight to DONE, no input accepted.
        do_start(10'd0);
        wait_init("z");
        chk("z done", done_flag, 1);
        chk("z in_ready", in_ready, 0);
        in_valid = 1'b1;
        bad_ready = 0; bad_valid = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (in_ready) bad_ready = 1;
            if (out_valid) bad_valid = 1;
        end
        in_valid = 1'b0;
        chk("z ready never", bad_ready, 0);
        chk("z valid never", bad_valid, 0);

        // Asynchronous reset while an output is waiting.
        do_start(10'd3);
        wait_init("rst");
        out_ready = 1'b0;
        in_char   = 8'h01;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        for (int n = 0; n < 300 && !out_valid; n++) tick();
        chk("rst pre out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async out_valid", out_valid, 0);
        chk("rst async done", done_flag, 0);
        chk("rst async in_ready", in_ready, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bad_ready = 0; bad_valid = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (in_ready) bad_ready = 1;
            if (out_valid) bad_valid = 1;
        end
        in_valid = 1'b0;
        chk("rst wait ready", bad_ready, 0);
        chk("rst wait valid", bad_valid, 0);
        do_start(10'd1);
        wait_init("rst restart");
        feed(8'h01, 8'h01, 1'b1, "rst after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mtf_encoder.md
# mtf_encoder

Move-to-front (MTF) encoder that sits directly downstream of the `bwt` block. It consumes the BWT-permuted byte stream one symbol at a time and emits, per symbol, that symbol's current rank in a 256-entry recency list, then moves the symbol to the front. The output is rank data with long zero runs, ready for the run-length/entropy stage. Stream length is programmed per block, and completion is flagged with `done_flag`, matching `bwt`.

## Interface
- No parameters. Alphabet size is fixed at 256 and symbol width at 8 bits.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle pulse. Samples `length`, rebuilds the list and clears `done_flag`.
- `length` input 10: number of symbols in the block, sampled on `start`.
- `in_char` input 8: BWT output byte.
- `in_valid` input 1: `in_char` is valid.
- `in_ready` output 1: block can accept a symbol this cycle.
- `out_rank` output 8: MTF rank of the accepted symbol.
- `out_valid` output 1: `out_rank` is valid.
- `out_ready` input 1: consumer accepts `out_rank`.
- `done_flag` output 1: all `length` symbols emitted; held until the next `start`.

## Operation
- List storage: `table[0:255]` of 8-bit entries. Index 0 is the most recently used symbol.
- States:
  - WAIT (reset state). `in_ready` = 0.
  - INIT: 256 cycles, writing `table[i] = i` for i = 0..255 using an 8-bit counter. Then go to IDLE.
  - IDLE: `in_ready` = 1 if the emitted count < `len_r`.
  - SCAN: search and shift the list.
  - OUT: hold the result until it is consumed.
  - DONE: `done_flag` = 1, `in_ready` = 0.
- On `in_valid && in_ready` in IDLE: latch `sym` = `in_char`, set `idx` = 0, go to SCAN.
- SCAN performs a single-pass search-and-shift, examining `table[idx]` once per cycle:
  - idx = 0, match: no write. `out_rank` = 0, go to OUT.
  - idx = 0, no match: `carry` ← `table[0]`, `table[0]` ← `sym`, `idx` ← 1.
  - idx > 0, match: `table[idx]` ← `carry`, `out_rank` ← `idx`, go to OUT.
  - idx > 0, no match: `table[idx]` ← `carry`, `carry` ← old `table[idx]`, `idx` increments.
  - A match always occurs by idx 255 because the list is a permutation. `idx` never wraps.
- OUT: `out_valid` = 1. On `out_ready`, increment the 10-bit `emit_cnt`. If the new count equals `len_r`, go to DONE; otherwise go to IDLE.
- `start`:
  - Accepted in every state and has priority over all other events.
  - Effects: `len_r` ← `length`, `emit_cnt` ← 0, `done_flag` ← 0, `out_valid` ← 0. Any in-flight symbol is dropped. Go to INIT.
  - `start` during INIT restarts the counter at 0.
- `length` = 0: after INIT, go directly to DONE. No symbol is accepted.
- `len_r` is 10 bits, so the maximum block is 1023 symbols, matching `bwt` addressing.

## Timing
- Reset values:
  - `in_ready` = 0, `out_valid` = 0, `out_rank` = 0, `done_flag` = 0.
  - State = WAIT, `len_r` = 0, `emit_cnt` = 0.
  - Table contents are undefined until INIT.
- `start` at edge E leads to `in_ready` = 1 from edge E+257 (256 INIT cycles plus the transition to IDLE), provided `len_r` > 0.
- Latency for a symbol of rank k: accepted at edge A, `out_valid` rises at edge A+k+1.
  - Rank 0: 1 cycle.
  - Rank 255: 256 cycles.
- `out_rank` and `out_valid` are registered and held stable while `out_valid && !out_ready`.
- Throughput:
  - `in_ready` is 0 in SCAN, OUT, INIT, WAIT and DONE; only one symbol is in flight.
  - A consumed output at edge C gives `in_ready` = 1 from edge C.
  - The next acceptance is at edge C+1 at the earliest.
- `done_flag` rises on the edge that consumes the last output and stays high until `start` or reset.
- Reset asserted mid-operation forces the reset values immediately, asynchronously. Only `start` leaves WAIT.
- `in_valid` while `in_ready` = 0 is ignored; no input is captured.

## Test plan
- Reset, then `start` with `length` = 4:
  - `in_ready` stays 0 for 256 cycles, then rises.
  - Feed 0x62, 0x62, 0x61, 0x62 with `out_ready` = 1.
  - Expect ranks 0x62, 0x00, 0x62, 0x01; `done_flag` rises after the 4th output.
- Latency check: fresh list, symbol 0x00 gives `out_valid` 1 cycle after acceptance; symbol 0xFF on a fresh list gives `out_valid` 256 cycles after acceptance with rank 0xFF.
- Backpressure: hold `out_ready` = 0 for 10 cycles while `out_valid` = 1.
  - `out_rank` stays constant and `in_ready` stays 0.
  - One cycle of `out_ready` gives exactly one count increment.
- `start` asserted mid-SCAN (symbol 0x80 on a fresh list) with `length` = 1:
  - In-flight symbol dropped; no `out_valid`.
  - INIT restarts; the following symbol 0x80 yields rank 0x80.
- `length` = 0: `start` leads to `done_flag` = 1 at INIT end, and `in_ready` never asserts.
- Asynchronous `rst_n` pulse during OUT: `out_valid` and `done_flag` drop immediately and the state is WAIT. `in_valid` is ignored until `start`.
